// File: rtl/biquad_coeff_sequencer_pkg.sv
// Shared types and encodings for the biquad coefficient load sequencer.
package biquad_coeff_sequencer_pkg;

  localparam int unsigned DW = 18;

  localparam logic ADR_LOW  = 1'b0;
  localparam logic ADR_XFER = 1'b1;
  localparam logic SEL_LOW  = 1'b0;
  localparam logic SEL_HIGH = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HI_WR,
    ST_HI_HOLD,
    ST_XF_WR,
    ST_XF_HOLD,
    ST_LO_WR,
    ST_LO_HOLD,
    ST_UPDATE,
    ST_SETTLE,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
  } coeff_pair_t;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          adr;
  } coeff_bus_t;

endpackage

// File: rtl/biquad_coeff_sequencer_mask_first_set.sv
// Lowest-set-bit index of a mask, with a flag telling whether any bit is set.
module mask_first_set #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  mask_i,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  // Descending scan so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o = IW'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/biquad_coeff_sequencer.sv
// Replays shadow coefficients into each selected channel's B1 chain over a
// shared load bus, then fires one atomic B1-to-B2 update to all of them.
module biquad_coeff_sequencer
  import biquad_coeff_sequencer_pkg::*;
#(
  parameter int unsigned NCH           = 4,
  parameter int unsigned CHW           = 2,
  parameter int unsigned UPDATE_SETTLE = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_wr_i,
  input  logic [CHW-1:0] cfg_ch_i,
  input  logic           cfg_sel_i,
  input  logic [DW-1:0]  cfg_dat_i,
  input  logic           commit_i,
  input  logic [NCH-1:0] commit_mask_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [DW-1:0]  coeff_dat_o,
  output logic           coeff_adr_o,
  output logic [NCH-1:0] coeff_wr_o,
  output logic [NCH-1:0] coeff_update_o
);

  localparam int unsigned CNTW = 4;

  state_e         state_q, state_d;
  logic [NCH-1:0] work_q, work_d;
  logic [NCH-1:0] snap_q, snap_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  coeff_pair_t    shadow_q [NCH];
  coeff_pair_t    shadow_d [NCH];
  coeff_pair_t    wk_q [NCH];
  coeff_pair_t    wk_d [NCH];
  coeff_bus_t     bus_q, bus_d;
  logic [NCH-1:0] wr_q, wr_d;
  logic [NCH-1:0] upd_q, upd_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           start;
  logic [NCH-1:0] start_mask;
  logic           fs_vld;
  logic [NCH-1:0] ch_oh;

  // Channel served next is always the lowest bit still set in the working mask.
  mask_first_set #(.N(NCH), .IW(CHW)) u_first (
    .mask_i (work_d),
    .idx_o  (ch_d),
    .vld_o  (fs_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q <= '0;
      snap_q <= '0;
      pend_q <= '0;
      ch_q   <= '0;
      cnt_q  <= '0;
      bus_q  <= '0;
      wr_q   <= '0;
      upd_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < int'(NCH); i++) begin
        shadow_q[i] <= '0;
        wk_q[i]     <= '0;
      end
    end else begin
      work_q   <= work_d;
      snap_q   <= snap_d;
      pend_q   <= pend_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      bus_q    <= bus_d;
      wr_q     <= wr_d;
      upd_q    <= upd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      shadow_q <= shadow_d;
      wk_q     <= wk_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    snap_d     = snap_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    wk_d       = wk_q;
    start      = 1'b0;
    start_mask = '0;

    if (cfg_wr_i && (32'(cfg_ch_i) < NCH)) begin
      if (cfg_sel_i == SEL_HIGH) shadow_d[cfg_ch_i].hi = cfg_dat_i;
      else                       shadow_d[cfg_ch_i].lo = cfg_dat_i;
    end

    if (commit_i && (state_q != ST_IDLE) && (state_q != ST_DONE))
      pend_d = pend_q | commit_mask_i;

    case (state_q)
      ST_IDLE: begin
        if (commit_i) begin
          start      = 1'b1;
          start_mask = commit_mask_i;
        end
      end
      ST_HI_WR:   state_d = ST_HI_HOLD;
      ST_HI_HOLD: state_d = ST_XF_WR;
      ST_XF_WR:   state_d = ST_XF_HOLD;
      ST_XF_HOLD: state_d = ST_LO_WR;
      ST_LO_WR:   state_d = ST_LO_HOLD;
      ST_LO_HOLD: begin
        work_d  = work_q & ~(NCH'(1) << ch_q);
        state_d = (|work_d) ? ST_HI_WR : ST_UPDATE;
      end
      ST_UPDATE: begin
        if (UPDATE_SETTLE == 0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SETTLE;
          cnt_d   = CNTW'(UPDATE_SETTLE - 1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CNTW'(1);
      end
      ST_DONE: begin
        // Commits collected while busy (plus one arriving now) restart immediately.
        start_mask = pend_q | (commit_i ? commit_mask_i : '0);
        pend_d     = '0;
        start      = |start_mask;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      work_d  = start_mask;
      snap_d  = start_mask;
      state_d = (|start_mask) ? ST_HI_WR : ST_DONE;
      for (int i = 0; i < int'(NCH); i++) begin
        if (start_mask[i]) wk_d[i] = shadow_q[i];
      end
    end
  end

  // Outputs decoded from the next state so they register alongside it.
  always_comb begin
    bus_d  = '0;
    wr_d   = '0;
    upd_d  = '0;
    busy_d = (state_d != ST_IDLE);
    done_d = 1'b0;
    ch_oh  = fs_vld ? (NCH'(1) << ch_d) : '0;

    case (state_d)
      ST_HI_WR: begin
        bus_d.dat = wk_d[ch_d].hi;
        bus_d.adr = ADR_LOW;
        wr_d      = ch_oh;
      end
      ST_HI_HOLD: begin
        bus_d.dat = wk_d[ch_d].hi;
        bus_d.adr = ADR_LOW;
      end
      ST_XF_WR: begin
        bus_d.dat = wk_d[ch_d].hi;
        bus_d.adr = ADR_XFER;
        wr_d      = ch_oh;
      end
      ST_XF_HOLD: begin
        bus_d.dat = wk_d[ch_d].hi;
        bus_d.adr = ADR_XFER;
      end
      ST_LO_WR: begin
        bus_d.dat = wk_d[ch_d].lo;
        bus_d.adr = ADR_LOW;
        wr_d      = ch_oh;
      end
      ST_LO_HOLD: begin
        bus_d.dat = wk_d[ch_d].lo;
        bus_d.adr = ADR_LOW;
      end
      ST_UPDATE: upd_d  = snap_d;
      ST_DONE:   done_d = 1'b1;
      default: ;
    endcase
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign coeff_dat_o    = bus_q.dat;
  assign coeff_adr_o    = bus_q.adr;
  assign coeff_wr_o     = wr_q;
  assign coeff_update_o = upd_q;

endmodule
